// File: rtl/cp0_unit_pkg.sv
// rtl/cp0_unit_pkg.sv - CP0 register numbers, ExcCodes, write masks and vector defaults
package cp0_unit_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    localparam logic [31:0] STATUS_WMASK   = 32'h0000FF03;
    localparam logic [31:0] CAUSE_WMASK    = 32'h00000300;
    localparam logic [31:0] STATUS_RESET   = 32'h10000000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'hBFC00380;
    localparam logic [31:0] DEF_INT_VECTOR = 32'hBFC00380;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count/Compare timer with prescaler and timer interrupt flag
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    logic [DW-1:0] div_q;
    logic          div_wrap;
    logic [31:0]   count_nxt;
    logic          count_upd;

    assign div_wrap = (div_q == DW'(COUNT_DIV - 1));

    // A software write to Count overrides the prescaled increment.
    always_comb begin
        count_nxt = count;
        count_upd = 1'b0;
        if (count_we) begin
            count_nxt = wdata;
            count_upd = 1'b1;
        end else if (div_wrap) begin
            count_nxt = count + 32'd1;
            count_upd = 1'b1;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            div_q     <= '0;
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            div_q <= (count_we || div_wrap) ? '0 : div_q + 1'b1;
            count <= count_nxt;
            if (compare_we)
                compare <= wdata;
            // Compare write acknowledges the interrupt even if a match lands the same cycle.
            if (compare_we)
                timer_int <= 1'b0;
            else if (count_upd && (count_nxt == compare) && (compare != 32'd0))
                timer_int <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_unit.sv
// rtl/cp0_unit.sv - MiniMIPS32 CP0: exception commit, ERET, MTC0/MFC0, interrupt request
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter int          NUM_HW_INT = 6,
    parameter int          COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR,
    parameter logic [31:0] INT_VECTOR = DEF_INT_VECTOR
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst,
    input  logic                  we,
    input  logic [4:0]            waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [4:0]            raddr,
    output logic [31:0]           data_o,
    input  logic [NUM_HW_INT-1:0] int_i,
    input  logic                  exc_valid_i,
    input  logic [4:0]            exccode_i,
    input  logic                  eret_i,
    input  logic [31:0]           pc_i,
    input  logic                  in_delay_i,
    input  logic [31:0]           badvaddr_i,
    output logic                  flush,
    output logic [31:0]           cp0_excaddr,
    output logic                  int_req_o,
    output logic                  timer_int_o,
    output logic [31:0]           status_o,
    output logic [31:0]           cause_o,
    output logic [31:0]           epc_o
);

    logic [31:0] badvaddr_q;
    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic        cause_bd;
    logic [7:0]  cause_ip;
    logic [4:0]  cause_exccode;
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_int;
    logic [5:0]  hw_int;
    logic        mtc0;
    logic        bypass;

    assign mtc0   = we & ~exc_valid_i & ~eret_i;
    assign bypass = mtc0 & (raddr == waddr);

    always_comb begin
        hw_int                 = '0;
        hw_int[NUM_HW_INT-1:0] = int_i;
    end

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .cpu_clk_50M (cpu_clk_50M),
        .cpu_rst     (cpu_rst),
        .count_we    (mtc0 && (waddr == CP0_COUNT)),
        .compare_we  (mtc0 && (waddr == CP0_COMPARE)),
        .wdata       (wdata),
        .count       (count),
        .compare     (compare),
        .timer_int   (timer_int)
    );

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            badvaddr_q    <= '0;
            status_q      <= STATUS_RESET;
            epc_q         <= '0;
            cause_bd      <= 1'b0;
            cause_ip      <= '0;
            cause_exccode <= '0;
        end else begin
            // IP[7] shares the line with the sixth hardware interrupt and the timer.
            cause_ip[6:2] <= hw_int[4:0];
            cause_ip[7]   <= hw_int[5] | timer_int;
            if (exc_valid_i) begin
                if (!status_q[1]) begin
                    epc_q    <= in_delay_i ? pc_i - 32'd4 : pc_i;
                    cause_bd <= in_delay_i;
                end
                status_q[1]   <= 1'b1;
                cause_exccode <= exccode_i;
                if (exccode_i == EXC_ADEL || exccode_i == EXC_ADES)
                    badvaddr_q <= badvaddr_i;
            end else if (eret_i) begin
                status_q[1] <= 1'b0;
            end else if (we) begin
                case (waddr)
                    CP0_BADVADDR: badvaddr_q    <= wdata;
                    CP0_STATUS:   status_q      <= apply_mask(status_q, wdata, STATUS_WMASK);
                    CP0_CAUSE:    cause_ip[1:0] <= wdata[9:8];
                    CP0_EPC:      epc_q         <= wdata;
                    default: ;
                endcase
            end
        end
    end

    assign status_o    = status_q;
    assign epc_o       = epc_q;
    assign cause_o     = {cause_bd, timer_int, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};
    assign timer_int_o = timer_int;
    assign int_req_o   = status_q[0] & ~status_q[1] & (|(status_q[15:8] & cause_ip));
    assign flush       = ~cpu_rst & (exc_valid_i | eret_i);

    always_comb begin
        cp0_excaddr = '0;
        if (!cpu_rst) begin
            if (exc_valid_i)
                cp0_excaddr = (exccode_i == EXC_INT) ? INT_VECTOR : EXC_VECTOR;
            else if (eret_i)
                cp0_excaddr = (we && waddr == CP0_EPC) ? wdata : epc_q;
        end
    end

    // MFC0 returns the post-write value when an MTC0 to the same register lands this cycle.
    always_comb begin
        data_o = '0;
        if (re && !cpu_rst) begin
            case (raddr)
                CP0_BADVADDR: data_o = bypass ? wdata : badvaddr_q;
                CP0_COUNT:    data_o = bypass ? wdata : count;
                CP0_COMPARE:  data_o = bypass ? wdata : compare;
                CP0_STATUS:   data_o = bypass ? apply_mask(status_q, wdata, STATUS_WMASK) : status_q;
                CP0_CAUSE:    data_o = bypass ? apply_mask(cause_o, wdata, CAUSE_WMASK) : cause_o;
                CP0_EPC:      data_o = bypass ? wdata : epc_q;
                default:      data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_unit.sv
// tb/tb_cp0_unit.sv - directed scoreboard bench for cp0_unit
module tb_cp0_unit;

    localparam logic [31:0] EXC_VEC = 32'hBFC00380;
    localparam logic [31:0] INT_VEC = 32'hBFC00400;

    logic        clk = 1'b0;
    logic        cpu_rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re;
    logic [4:0]  raddr;
    logic [31:0] data_o;
    logic [5:0]  int_i;
    logic        exc_valid_i;
    logic [4:0]  exccode_i;
    logic        eret_i;
    logic [31:0] pc_i;
    logic        in_delay_i;
    logic [31:0] badvaddr_i;
    logic        flush;
    logic [31:0] cp0_excaddr;
    logic        int_req_o;
    logic        timer_int_o;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;

    int total = 0;
    int bad   = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    cp0_unit #(
        .NUM_HW_INT (6),
        .COUNT_DIV  (2),
        .EXC_VECTOR (EXC_VEC),
        .INT_VECTOR (INT_VEC)
    ) dut (
        .cpu_clk_50M (clk),
        .cpu_rst     (cpu_rst),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .re          (re),
        .raddr       (raddr),
        .data_o      (data_o),
        .int_i       (int_i),
        .exc_valid_i (exc_valid_i),
        .exccode_i   (exccode_i),
        .eret_i      (eret_i),
        .pc_i        (pc_i),
        .in_delay_i  (in_delay_i),
        .badvaddr_i  (badvaddr_i),
        .flush       (flush),
        .cp0_excaddr (cp0_excaddr),
        .int_req_o   (int_req_o),
        .timer_int_o (timer_int_o),
        .status_o    (status_o),
        .cause_o     (cause_o),
        .epc_o       (epc_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty obs=%h exp=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s obs=%h exp=%h", t, obs, e);
            end
        end
    endtask

    task automatic idle();
        we = 0; re = 0; exc_valid_i = 0; eret_i = 0;
    endtask

    initial begin
        int n;
        cpu_rst = 1; we = 0; waddr = 0; wdata = 0; re = 0; raddr = 0; int_i = 0;
        exc_valid_i = 0; exccode_i = 0; eret_i = 0; pc_i = 0; in_delay_i = 0; badvaddr_i = 0;
        tick();
        exc_valid_i = 1; re = 1; raddr = 5'd12;
        expect_val("rst_flush", 32'd0);     check({31'd0, flush});
        expect_val("rst_excaddr", 32'd0);   check(cp0_excaddr);
        expect_val("rst_data", 32'd0);      check(data_o);
        tick();
        idle(); cpu_rst = 0;
        expect_val("rst_status", 32'h10000000); check(status_o);
        expect_val("rst_cause", 32'd0);         check(cause_o);
        expect_val("rst_epc", 32'd0);           check(epc_o);
        expect_val("rst_ireq", 32'd0);          check({31'd0, int_req_o});

        // Test 1: masked Status write and unimplemented register
        we = 1; waddr = 5'd12; wdata = 32'hFFFFFFFF; re = 1; raddr = 5'd12;
        expect_val("st_bypass", 32'h1000FF03); #1 check(data_o);
        tick(); we = 0;
        expect_val("st_read", 32'h1000FF03); check(data_o);
        raddr = 5'd5;
        expect_val("reg5_read", 32'd0); #1 check(data_o);
        idle();

        // Test 2: Count/Compare timer
        we = 1; waddr = 5'd12; wdata = 32'h00008001; tick();
        waddr = 5'd11; wdata = 32'd10; tick();
        waddr = 5'd9;  wdata = 32'd0;  tick();
        we = 0;
        n = 0;
        while (!timer_int_o && n < 100) begin
            tick();
            n++;
        end
        expect_val("ti_latency", 32'd20); check(n);
        tick(); tick();
        expect_val("ip7", 32'd1);     check({31'd0, cause_o[15]});
        expect_val("int_req", 32'd1); check({31'd0, int_req_o});
        we = 1; waddr = 5'd11; wdata = 32'd50; tick(); we = 0;
        expect_val("ti_clear", 32'd0); check({31'd0, timer_int_o});

        // Test 3: AdEL in a delay slot
        exc_valid_i = 1; exccode_i = 5'h04; pc_i = 32'h100; in_delay_i = 1; badvaddr_i = 32'h203;
        expect_val("adel_flush", 32'd1);   #1 check({31'd0, flush});
        expect_val("adel_vec", EXC_VEC);   check(cp0_excaddr);
        tick(); idle(); in_delay_i = 0;
        expect_val("adel_epc", 32'hFC);    check(epc_o);
        expect_val("adel_bd", 32'd1);      check({31'd0, cause_o[31]});
        expect_val("adel_exl", 32'd1);     check({31'd0, status_o[1]});
        expect_val("adel_code", 32'h04);   check({27'd0, cause_o[6:2]});
        re = 1; raddr = 5'd8;
        expect_val("adel_bva", 32'h203);   #1 check(data_o);
        re = 0;

        // Test 4: nested exception keeps EPC, then ERET
        exc_valid_i = 1; exccode_i = 5'h0C; pc_i = 32'h300; badvaddr_i = 32'hDEAD;
        tick(); idle();
        expect_val("ov_epc", 32'hFC);      check(epc_o);
        expect_val("ov_code", 32'h0C);     check({27'd0, cause_o[6:2]});
        re = 1; raddr = 5'd8;
        expect_val("ov_bva", 32'h203);     #1 check(data_o);
        re = 0;
        eret_i = 1;
        expect_val("eret_addr", 32'hFC);   #1 check(cp0_excaddr);
        tick(); idle();
        expect_val("eret_exl", 32'd0);     check({31'd0, status_o[1]});

        // Test 5: ERET with same-cycle EPC write, Count bypass
        eret_i = 1; we = 1; waddr = 5'd14; wdata = 32'h400;
        expect_val("eret_byp", 32'h400);   #1 check(cp0_excaddr);
        tick(); idle();
        expect_val("eret_drop", 32'hFC);   check(epc_o);
        we = 1; waddr = 5'd9; wdata = 32'd7; re = 1; raddr = 5'd9;
        expect_val("cnt_byp", 32'd7);      #1 check(data_o);
        tick(); we = 0;
        expect_val("cnt_read", 32'd7);     check(data_o);
        idle();

        // Test 6: exception blocks MTC0; Int vector; reset mid-count
        exc_valid_i = 1; exccode_i = 5'h00; pc_i = 32'h500; we = 1; waddr = 5'd12; wdata = 32'd0;
        expect_val("int_vec", INT_VEC);    #1 check(cp0_excaddr);
        tick(); idle();
        expect_val("blk_status", 32'h10008003); check(status_o);
        expect_val("blk_epc", 32'h500);         check(epc_o);
        tick(); tick(); tick();
        cpu_rst = 1; tick(); cpu_rst = 0;
        re = 1; raddr = 5'd9;
        expect_val("rst_count", 32'd0);         #1 check(data_o);
        expect_val("rst_status2", 32'h10000000); check(status_o);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
